// File: rtl/fir_frame_sequencer.sv
// rtl/fir_frame_sequencer.sv - frame sequencer around one FIR instance
// Clears the filter per frame, streams samples, flushes the tail with zeros and tags sop/eop.
module fir_frame_sequencer #(
  parameter int DATA_WIDTH    = 16,
  parameter int OUT_WIDTH     = 26,
  parameter int NUM_TAPS      = 37,
  parameter int WARMUP        = (NUM_TAPS + 1) / 2,
  parameter int FLUSH_LEN     = NUM_TAPS - 1,
  parameter int CLEAR_CYCLES  = 2,
  parameter int MAX_FRAME     = 4096,
  parameter int DRAIN_TIMEOUT = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [DATA_WIDTH-1:0] s_data,
  input  logic                  s_last,
  output logic                  fir_rst,
  output logic                  fir_valid_in,
  output logic [DATA_WIDTH-1:0] fir_din,
  input  logic                  fir_valid_out,
  input  logic [OUT_WIDTH-1:0]  fir_dout,
  output logic                  m_valid,
  output logic [OUT_WIDTH-1:0]  m_data,
  output logic                  m_sop,
  output logic                  m_eop,
  output logic                  frame_done,
  output logic [2:0]            frame_err
);

  localparam int CW   = $clog2(MAX_FRAME + FLUSH_LEN + 1);
  localparam int TMAX = (CLEAR_CYCLES > DRAIN_TIMEOUT) ? CLEAR_CYCLES : DRAIN_TIMEOUT;
  localparam int TW   = $clog2(TMAX + 1);
  localparam int FW   = $clog2(FLUSH_LEN + 1);

  localparam logic [CW-1:0] WARMUP_C     = CW'(WARMUP);
  localparam logic [CW-1:0] MAX_C        = CW'(MAX_FRAME);
  localparam logic [TW-1:0] CLEAR_LAST   = TW'(CLEAR_CYCLES - 1);
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(DRAIN_TIMEOUT - 1);
  localparam logic [FW-1:0] FLUSH_LAST   = FW'(FLUSH_LEN - 1);

  typedef enum logic [2:0] {IDLE, CLEAR, RUN, FLUSH, DRAIN} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] in_cnt, out_cnt, exp_cnt;
  logic [FW-1:0] flush_cnt;
  logic [TW-1:0] tmr;
  logic          accept, at_max, drain_done, drain_timeout, out_live, stray, clr;

  assign s_ready = (state == RUN);
  assign accept  = s_valid && s_ready;
  assign at_max  = (in_cnt == MAX_C - 1'b1);
  assign exp_cnt = (in_cnt > WARMUP_C) ? in_cnt - WARMUP_C : '0;

  assign drain_done    = (state == DRAIN) && (out_cnt >= exp_cnt);
  assign drain_timeout = (state == DRAIN) && !drain_done && !fir_valid_out && (tmr == TIMEOUT_LAST);

  // Anything the filter emits outside the frame window is dropped and flagged.
  assign out_live = fir_valid_out &&
                    ((state == RUN) || (state == FLUSH) || ((state == DRAIN) && !drain_done));
  assign stray    = fir_valid_out && !out_live;
  assign clr      = (state == CLEAR) || ((state == IDLE) && s_valid);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (s_valid) state_nxt = CLEAR;
      CLEAR:   if (tmr == CLEAR_LAST) state_nxt = RUN;
      RUN:     if (accept && (s_last || at_max)) state_nxt = FLUSH;
      FLUSH:   if (flush_cnt == FLUSH_LAST) state_nxt = DRAIN;
      DRAIN:   if (drain_done || drain_timeout) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmr <= '0;
    end else begin
      case (state)
        CLEAR:   tmr <= tmr + 1'b1;
        DRAIN:   tmr <= fir_valid_out ? '0 : tmr + 1'b1;
        default: tmr <= '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fir_rst      <= 1'b1;
      fir_valid_in <= 1'b0;
      fir_din      <= '0;
      m_valid      <= 1'b0;
      m_data       <= '0;
      m_sop        <= 1'b0;
      m_eop        <= 1'b0;
      frame_done   <= 1'b0;
      frame_err    <= '0;
      in_cnt       <= '0;
      out_cnt      <= '0;
      flush_cnt    <= '0;
    end else begin
      fir_rst      <= (state_nxt == CLEAR);
      fir_valid_in <= accept || (state == FLUSH);
      fir_din      <= accept ? s_data : '0;
      m_valid      <= out_live;
      if (out_live) m_data <= fir_dout;
      m_sop        <= out_live && (out_cnt == '0);
      // The final flush sample is still in flight until DRAIN, so eop is only decided there.
      m_eop        <= out_live && (state == DRAIN) && (out_cnt == exp_cnt - 1'b1);
      frame_done   <= drain_done;
      if (clr) begin
        in_cnt    <= '0;
        out_cnt   <= '0;
        flush_cnt <= '0;
        frame_err <= '0;
      end else begin
        if (accept || (state == FLUSH)) in_cnt <= in_cnt + 1'b1;
        if (out_live) out_cnt <= out_cnt + 1'b1;
        if (state == FLUSH) flush_cnt <= flush_cnt + 1'b1;
        if (accept && !s_last && at_max) frame_err[0] <= 1'b1;
        if (drain_timeout) frame_err[1] <= 1'b1;
        if (stray) frame_err[2] <= 1'b1;
      end
    end
  end

endmodule

// File: doc/fir_frame_sequencer.md
Name: fir_frame_sequencer

Overview:
- Frame-level controller that sequences one FIR filter instance (sync active-high `rst`, `valid_in`/`din` in, `valid_out`/`dout` out, no backpressure).
- Per frame it clears the filter, streams the frame's samples into it, then injects zero samples to flush the tail.
- It passes the filter outputs downstream with start-of-frame/end-of-frame markers and reports a per-frame completion status.
- It sits between the sample source (ready/valid) and the filter, and between the filter and the downstream consumer.

Parameters:
- DATA_WIDTH, 16, input sample width (equal to the filter's input width).
- OUT_WIDTH, 26, filter output width.
- NUM_TAPS, 37, filter tap count (informational; sets the FLUSH_LEN default).
- WARMUP, 19, outputs suppressed by the filter after its reset; default (NUM_TAPS+1)/2.
- FLUSH_LEN, 36, zero samples injected after the last input; default NUM_TAPS-1.
- CLEAR_CYCLES, 2, cycles `fir_rst` is held high per frame; minimum 1.
- MAX_FRAME, 4096, maximum accepted samples per frame.
- DRAIN_TIMEOUT, 64, idle cycles tolerated in DRAIN before abort.

Ports:
- `clk`  in  1  clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `s_valid`  in  1  input sample valid.
- `s_ready`  out  1  sequencer accepts a sample.
- `s_data`  in  DATA_WIDTH  input sample.
- `s_last`  in  1  last sample of the frame.
- `fir_rst`  out  1  filter synchronous reset.
- `fir_valid_in`  out  1  filter `valid_in`.
- `fir_din`  out  DATA_WIDTH  filter `din`.
- `fir_valid_out`  in  1  filter `valid_out`.
- `fir_dout`  in  OUT_WIDTH  filter `dout`.
- `m_valid`  out  1  output sample valid (downstream must always accept).
- `m_data`  out  OUT_WIDTH  output sample.
- `m_sop`  out  1  first output of the frame.
- `m_eop`  out  1  last output of the frame.
- `frame_done`  out  1  one-cycle pulse on normal frame completion.
- `frame_err`  out  3  sticky error bits: [0] overlength, [1] drain timeout, [2] stray filter output. Cleared on the next entry to CLEAR.

Behaviour:
- Reset (`rst_n` low, async):
  - State = IDLE; all counters = 0.
  - `s_ready`=0, `fir_rst`=1, `fir_valid_in`=0, `fir_din`=0, `m_valid`/`m_sop`/`m_eop`=0, `frame_done`=0, `frame_err`=0.
- All outputs are registered, with one exception: `s_ready` is a decode of the state (high only in RUN).
- IDLE:
  - `fir_rst`=0.
  - `s_valid`=1 → CLEAR. The sample is not consumed.
- CLEAR:
  - `fir_rst`=1 for exactly CLEAR_CYCLES cycles.
  - `in_cnt`, `out_cnt`, `flush_cnt` and `frame_err` are zeroed.
  - Then → RUN.
- RUN:
  - On each handshake (`s_valid` & `s_ready`): the next cycle drives `fir_valid_in`=1 with `fir_din`=`s_data`, and `in_cnt`++.
  - Gaps in `s_valid` produce gaps in `fir_valid_in`.
  - Accepted with `s_last`=1 → FLUSH.
  - Accepted with `in_cnt` reaching MAX_FRAME and `s_last`=0 → FLUSH, set `frame_err[0]`. Later source samples wait for the next frame.
- FLUSH:
  - `s_ready`=0.
  - `fir_valid_in`=1 and `fir_din`=0 on FLUSH_LEN consecutive cycles; `in_cnt` increments on each.
  - Then → DRAIN.
- Expected output count: E = `in_cnt` − WARMUP, saturating at 0.
- Output path, active in RUN, FLUSH and DRAIN:
  - `m_valid`=`fir_valid_out` and `m_data`=`fir_dout`, both registered (1-cycle latency); `out_cnt`++ on each.
  - `m_sop`=1 when `out_cnt`==0.
  - `m_eop`=1 when `out_cnt`==E−1, evaluated against the final E (valid in DRAIN). An eop can only fall in DRAIN, because at least one flush sample is still outstanding before then.
- DRAIN:
  - `out_cnt`==E → IDLE with a `frame_done` pulse. If E==0 this happens immediately, and no sop/eop is emitted.
  - DRAIN_TIMEOUT cycles with no `fir_valid_out` → IDLE, set `frame_err[1]`, no `frame_done`.
- Stray output: `fir_valid_out`=1 in IDLE or CLEAR, or beyond E in DRAIN.
  - The sample is dropped (`m_valid` stays 0) and `frame_err[2]` is set.
  - In CLEAR, the flag is set and then cleared by CLEAR's own zeroing.
- Counter widths: `in_cnt`/`out_cnt` use $clog2(MAX_FRAME+FLUSH_LEN+1) bits. There is no wrap within a frame.
- Simultaneous `s_last` and overlength on the same accepted sample: treated as normal last, no error.
- Reset mid-frame: immediate return to IDLE. `fir_rst`=1 holds the filter cleared while `rst_n` is low. No partial eop or done is emitted.

Test Plan:
- 4-sample frame {1000,0,0,0}, `s_last` on the 4th, `s_valid` continuous:
  - `fir_rst` high 2 cycles.
  - 40 `fir_valid_in` pulses (4 data + 36 zeros).
  - 21 `m_valid` outputs, `m_sop` on the 1st, `m_eop` on the 21st, then one `frame_done` pulse.
- Same frame with `s_valid` toggling 1/0 every cycle → `fir_valid_in` gaps mirror the input; identical output count, sop/eop placement and `m_data` sequence.
- 4097 samples without `s_last` (MAX_FRAME=4096):
  - The 4096th accepted sample forces FLUSH and sets `frame_err[0]`.
  - E = 4096+36−19 = 4113 outputs, then `frame_done`.
  - The 4097th sample starts the next frame.
- Filter stub that never asserts `fir_valid_out` → after FLUSH plus 64 idle cycles: IDLE, `frame_err[1]`=1, `frame_done` never pulses.
- `fir_valid_out` pulsed while IDLE → no `m_valid`, `frame_err[2]`=1; the next frame's CLEAR resets `frame_err` to 0.
- `rst_n` pulled low for 1 cycle during FLUSH of a 10-sample frame → all outputs at reset values asynchronously, state IDLE, no `m_eop` or `frame_done`; the next frame then runs normally.
